// File: rtl/mac_accumulator_if.sv
// Handshake and data bundle between the AND-array lanes, the MAC/search
// accumulator and its result consumer.
interface mac_accumulator_if #(
  parameter int ACC_W = 20
) ();
  logic             start;
  logic             mode_mac;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [127:0]     add_flat;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] mac_result;
  logic [15:0]      match_vec;
  logic [4:0]       match_cnt;
  logic             busy;
  logic             err;

  modport slave (
    input  start, mode_mac, in_valid, in_last, add_flat, out_ready,
    output in_ready, out_valid, mac_result, match_vec, match_cnt, busy, err
  );

  modport master (
    output start, mode_mac, in_valid, in_last, add_flat, out_ready,
    input  in_ready, out_valid, mac_result, match_vec, match_cnt, busy, err
  );
endinterface

// File: rtl/mac_accumulator.sv
// Reduces sixteen 8-bit lanes through a two-stage adder tree and either
// shift-accumulates bit-planes (MAC) or counts match bits (search).
module mac_accumulator #(
  parameter int INPUT_BITS = 8,
  parameter int LANES      = 16,
  parameter int ACC_W      = 12 + INPUT_BITS
) (
  input logic              clk_inv,
  input logic              rst,
  mac_accumulator_if.slave bus
);
  localparam int PAIRS = LANES / 2;
  localparam int CNT_W = $clog2(INPUT_BITS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t                  r_state, w_next;
  logic                    w_inReady, w_outValid, w_busy, w_accept, w_load, w_open;
  logic [1:0]              r_drainCnt;
  logic [PAIRS-1:0][8:0]   w_pair, r_s1Pair;
  logic [LANES-1:0]        w_match, r_s1Match, r_s2Match, r_lastMatch;
  logic                    r_s1Valid, r_s1Last, r_s2Valid, r_s2Last;
  logic [11:0]             w_treeSum, r_s2Sum;
  logic [ACC_W-1:0]        r_acc, r_macResult;
  logic [CNT_W-1:0]        r_beatCnt;
  logic [4:0]              r_lastCnt, r_matchCnt;
  logic [15:0]             r_matchVec;
  logic                    r_mode, r_err;

  always_ff @(posedge clk_inv or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_inReady  = 1'b0;
    w_outValid = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = ACCUM;
      end
      ACCUM: begin
        w_inReady = 1'b1;
        if (bus.in_valid && bus.in_last) w_next = DRAIN;
      end
      DRAIN: if (r_drainCnt == 2'd2) w_next = HOLD;
      HOLD: begin
        w_outValid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = w_inReady & bus.in_valid;
  assign w_load   = (r_state == DRAIN) && (r_drainCnt == 2'd2);
  assign w_open   = (r_state == IDLE) && bus.start;

  always_comb begin
    w_pair  = '0;
    w_match = '0;
    for (int i = 0; i < PAIRS; i++)
      w_pair[i] = {1'b0, bus.add_flat[16*i +: 8]} + {1'b0, bus.add_flat[16*i+8 +: 8]};
    for (int i = 0; i < LANES; i++)
      w_match[i] = bus.add_flat[8*i];
  end

  always_comb begin
    w_treeSum = '0;
    for (int i = 0; i < PAIRS; i++)
      w_treeSum = w_treeSum + {3'b0, r_s1Pair[i]};
  end

  // Valid/last flags travel alongside each beat; data registers only load on real beats.
  always_ff @(posedge clk_inv or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
      r_s1Pair  <= '0;
      r_s1Match <= '0;
      r_s2Valid <= 1'b0;
      r_s2Last  <= 1'b0;
      r_s2Sum   <= '0;
      r_s2Match <= '0;
    end else begin
      r_s1Valid <= w_accept;
      r_s1Last  <= w_accept & bus.in_last;
      r_s2Valid <= r_s1Valid;
      r_s2Last  <= r_s1Last;
      if (w_accept) begin
        r_s1Pair  <= w_pair;
        r_s1Match <= w_match;
      end
      if (r_s1Valid) begin
        r_s2Sum   <= w_treeSum;
        r_s2Match <= r_s1Match;
      end
    end
  end

  always_ff @(posedge clk_inv or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_beatCnt   <= '0;
      r_err       <= 1'b0;
      r_mode      <= 1'b0;
      r_lastMatch <= '0;
      r_lastCnt   <= '0;
    end else if (w_open) begin
      r_acc       <= '0;
      r_beatCnt   <= '0;
      r_err       <= 1'b0;
      r_mode      <= bus.mode_mac;
      r_lastMatch <= '0;
      r_lastCnt   <= '0;
    end else begin
      if (r_s2Valid) begin
        if (r_mode) r_acc <= (r_acc << 1) + {{(ACC_W-12){1'b0}}, r_s2Sum};
        else        r_acc <= r_acc + {{(ACC_W-12){1'b0}}, r_s2Sum};
      end
      if (r_s2Valid && r_s2Last) begin
        r_lastMatch <= r_s2Match;
        r_lastCnt   <= r_s2Sum[4:0];
      end
      // Counter saturates; an overrun beat still accumulates but flags the error.
      if (w_accept) begin
        if (r_beatCnt == CNT_W'(INPUT_BITS)) begin
          if (!bus.in_last) r_err <= 1'b1;
        end else begin
          r_beatCnt <= r_beatCnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_inv or posedge rst) begin
    if (rst) begin
      r_drainCnt  <= '0;
      r_macResult <= '0;
      r_matchVec  <= '0;
      r_matchCnt  <= '0;
    end else begin
      r_drainCnt <= (r_state == DRAIN) ? r_drainCnt + 2'd1 : 2'd0;
      if (w_load) begin
        r_macResult <= r_acc;
        r_matchVec  <= r_mode ? 16'h0 : r_lastMatch;
        r_matchCnt  <= r_mode ? 5'd0  : r_lastCnt;
      end
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.out_valid  = w_outValid;
  assign bus.busy       = w_busy;
  assign bus.err        = r_err;
  assign bus.mac_result = r_macResult;
  assign bus.match_vec  = r_matchVec;
  assign bus.match_cnt  = r_matchCnt;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed checks of mac_accumulator: MAC and search results, latency,
// backpressure, overrun error and mid-operation reset.
module tb_mac_accumulator;
  logic clk_inv = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  localparam logic [127:0] SEARCH_VEC = (128'h1 << 0) | (128'h1 << 24) | (128'h1 << 120);

  mac_accumulator_if #(.ACC_W(20)) bus ();

  mac_accumulator #(.INPUT_BITS(8), .LANES(16), .ACC_W(20)) dut (
    .clk_inv(clk_inv),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_inv = ~clk_inv;

  task automatic startOp(input logic mode);
    bus.start    = 1'b1;
    bus.mode_mac = mode;
    @(negedge clk_inv);
    bus.start    = 1'b0;
  endtask

  task automatic sendBeat(input logic [127:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.add_flat = d;
    @(negedge clk_inv);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.add_flat = '0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk_inv);
      n++;
    end
  endtask

  task automatic releaseResult();
    bus.out_ready = 1'b1;
    @(negedge clk_inv);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.mode_mac  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.add_flat  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk_inv);
    rst = 1'b0;
    @(negedge clk_inv);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.mac_result !== 20'd0) begin bad++; $display("[TB] FAIL reset_result got=%0d want=0", bus.mac_result); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", bus.err); end
  endtask

  task automatic test_mac_single();
    startOp(1'b1);
    for (int i = 0; i < 8; i++) sendBeat(128'hFF, i == 7);
    waitValid(cyc);
    total++; if (cyc !== 3) begin bad++; $display("[TB] FAIL single_latency got=%0d want=3", cyc); end
    total++; if (bus.mac_result !== 20'd65025) begin bad++; $display("[TB] FAIL single_result got=%0d want=65025", bus.mac_result); end
    total++; if (bus.match_vec !== 16'h0) begin bad++; $display("[TB] FAIL single_match_vec got=%h want=0000", bus.match_vec); end
    total++; if (bus.match_cnt !== 5'd0) begin bad++; $display("[TB] FAIL single_match_cnt got=%0d want=0", bus.match_cnt); end
    releaseResult();
  endtask

  task automatic test_mac_full();
    startOp(1'b1);
    for (int i = 0; i < 8; i++) sendBeat({16{8'hFF}}, i == 7);
    waitValid(cyc);
    total++; if (cyc !== 3) begin bad++; $display("[TB] FAIL full_latency got=%0d want=3", cyc); end
    total++; if (bus.mac_result !== 20'd1040400) begin bad++; $display("[TB] FAIL full_result got=%0d want=1040400", bus.mac_result); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL full_err got=%b want=0", bus.err); end
    releaseResult();
  endtask

  task automatic test_search();
    bus.start    = 1'b1;
    bus.mode_mac = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.add_flat = '1;
    @(negedge clk_inv);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.add_flat = '0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL search_start_beat_ignored in_ready got=%b want=1", bus.in_ready); end
    sendBeat(SEARCH_VEC, 1'b1);
    waitValid(cyc);
    total++; if (cyc !== 3) begin bad++; $display("[TB] FAIL search_latency got=%0d want=3", cyc); end
    total++; if (bus.match_vec !== 16'h8009) begin bad++; $display("[TB] FAIL search_match_vec got=%h want=8009", bus.match_vec); end
    total++; if (bus.match_cnt !== 5'd3) begin bad++; $display("[TB] FAIL search_match_cnt got=%0d want=3", bus.match_cnt); end
    total++; if (bus.mac_result !== 20'd3) begin bad++; $display("[TB] FAIL search_result got=%0d want=3", bus.mac_result); end
    releaseResult();
  endtask

  task automatic test_backpressure();
    startOp(1'b0);
    sendBeat(SEARCH_VEC, 1'b1);
    waitValid(cyc);
    total++; if (cyc !== 3) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=3", cyc); end
    for (int k = 0; k < 5; k++) begin
      bus.start    = (k == 2);
      bus.mode_mac = 1'b1;
      @(negedge clk_inv);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid cycle=%0d got=%b want=1", k, bus.out_valid); end
      total++; if (bus.mac_result !== 20'd3) begin bad++; $display("[TB] FAIL bp_hold_result cycle=%0d got=%0d want=3", k, bus.mac_result); end
      total++; if (bus.match_vec !== 16'h8009) begin bad++; $display("[TB] FAIL bp_hold_vec cycle=%0d got=%h want=8009", k, bus.match_vec); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_in_ready cycle=%0d got=%b want=0", k, bus.in_ready); end
    end
    bus.start = 1'b0;
    releaseResult();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_busy got=%b want=0", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_start_ignored in_ready got=%b want=0", bus.in_ready); end
  endtask

  task automatic test_bubbles_err();
    startOp(1'b1);
    for (int i = 1; i <= 10; i++) begin
      sendBeat(128'h1, i == 10);
      total++;
      if (bus.err !== (i >= 9)) begin
        bad++; $display("[TB] FAIL bubble_err beat=%0d got=%b want=%b", i, bus.err, (i >= 9));
      end
      if (i < 10) @(negedge clk_inv);
    end
    waitValid(cyc);
    total++; if (cyc !== 3) begin bad++; $display("[TB] FAIL bubble_latency got=%0d want=3", cyc); end
    total++; if (bus.mac_result !== 20'd1023) begin bad++; $display("[TB] FAIL bubble_result got=%0d want=1023", bus.mac_result); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("[TB] FAIL bubble_err_hold got=%b want=1", bus.err); end
    releaseResult();
  endtask

  task automatic test_reset_mid();
    startOp(1'b1);
    for (int i = 0; i < 4; i++) sendBeat(128'hFF, 1'b0);
    rst = 1'b1;
    @(negedge clk_inv);
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.mac_result !== 20'd0) begin bad++; $display("[TB] FAIL midrst_result got=%0d want=0", bus.mac_result); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_err got=%b want=0", bus.err); end
    startOp(1'b1);
    for (int i = 0; i < 8; i++) sendBeat(128'h01, i == 7);
    waitValid(cyc);
    total++; if (cyc !== 3) begin bad++; $display("[TB] FAIL post_rst_latency got=%0d want=3", cyc); end
    total++; if (bus.mac_result !== 20'd255) begin bad++; $display("[TB] FAIL post_rst_result got=%0d want=255", bus.mac_result); end
    releaseResult();
  endtask

  initial begin
    test_reset();
    test_mac_single();
    test_mac_full();
    test_search();
    test_backpressure();
    test_bubbles_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream stage of the array AND logic. Consumes its sixteen 8-bit lane outputs (add0..add15) once per cycle.
- MAC mode: reduces the 16 lanes through a registered adder tree, then shift-accumulates bit-serial input planes (MSB first) into a multi-bit dot-product result.
- Search mode: the lanes carry match bits. The block reports the 16-bit match vector and its population count.
- Results are presented through a valid/ready output handshake, with backpressure toward the array.

Parameters:
- INPUT_BITS, 8, number of bit-planes per MAC operation (one data_in bit per row per beat).
- LANES, 16, number of 8-bit lanes (fixed at 16 in this revision).
- ACC_W, 20, accumulator width = 12 + INPUT_BITS.

Ports:
- clk_inv  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a new operation; accepted only in IDLE.
- mode_mac  in  1  sampled with start: 1 = MAC, 0 = search.
- in_valid  in  1  add_flat carries a valid beat.
- in_last  in  1  qualifies the final beat of the operation.
- in_ready  out  1  block accepts a beat this cycle.
- add_flat  in  128  {add15,...,add0}; lane i occupies bits [8i+7:8i].
- out_valid  out  1  result registers are valid.
- out_ready  in  1  consumer accepts the result.
- mac_result  out  ACC_W  accumulated dot product (MAC mode); popcount, zero-extended (search mode).
- match_vec  out  16  bit0 of each lane on the last search beat; 0 in MAC mode.
- match_cnt  out  5  popcount of match_vec.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky; set when more than INPUT_BITS beats arrive without in_last. Cleared by start or rst.

Behaviour:
- Reset state: FSM in IDLE; accumulator, pipeline registers, beat counter, mac_result, match_vec, match_cnt, out_valid and err all 0. in_ready is 0.
- FSM states: IDLE, ACCUM, DRAIN, HOLD.
  - IDLE: start goes to ACCUM. In the same cycle it latches mode, clears acc, the beat counter and err.
  - ACCUM: in_ready = 1. A beat is accepted when in_valid && in_ready. A beat with in_last goes to DRAIN.
  - DRAIN: in_ready = 0. Waits 2 cycles for the pipeline to empty, then loads the output registers and goes to HOLD.
  - HOLD: out_valid = 1. out_ready returns to IDLE with out_valid cleared the next cycle. Outputs stay stable until out_ready.
- Adder-tree pipeline:
  - Stage 1 registers 8 pairwise 9-bit sums.
  - Stage 2 registers the 12-bit total of all 16 lanes.
  - An accepted beat's sum reaches the accumulator 2 cycles after acceptance. A valid bit travels with each beat; bubbles (in_valid low) do not touch acc.
- Accumulator update on a valid stage-2 sum:
  - MAC: acc <= (acc << 1) + sum, all unsigned, width ACC_W.
  - Search: acc <= acc + sum.
  - The maximum MAC value (4080 × (2^INPUT_BITS − 1)) fits ACC_W, so no overflow is possible.
- Search mode: match_vec captures bit0 of each lane from the last beat, delayed to align with the pipeline. match_cnt equals the stage-2 sum of that beat. For a multi-beat search, mac_result is the total match count across all beats.
- Beat counter increments on each accepted beat and saturates at INPUT_BITS. An accepted beat when the counter is already INPUT_BITS and in_last is low sets err. Accumulation continues regardless.
- start outside IDLE is ignored.
- in_valid in IDLE, DRAIN or HOLD is ignored (in_ready = 0).
- A beat with in_valid and in_last asserted in the same cycle as start is not accepted; the first beat is sampled the cycle after start.
- rst asserted mid-operation aborts immediately to the reset state; no partial result is emitted.

Test Plan:
- MAC, single active lane: start(mode_mac=1); 8 beats with lane0 = 0xFF and other lanes 0, last beat flagged -> out_valid exactly 3 cycles after the last beat is accepted; mac_result = 65025; match_vec = 0.
- MAC, full scale: 8 beats with all lanes = 0xFF -> mac_result = 1040400, no wrap; err = 0.
- Search: start(mode_mac=0); one beat with lanes 0, 3 and 15 = 0x01 and the rest 0, in_last = 1 -> match_vec = 16'h8009, match_cnt = 3, mac_result = 3.
- Backpressure: hold out_ready = 0 for 5 cycles in HOLD -> outputs stable, in_ready = 0, and a start pulse is ignored. Assert out_ready -> out_valid clears next cycle and busy drops.
- Bubbles and error: 10 MAC beats of lane0 = 1 with in_valid gaps and no in_last until beat 10 -> err = 1 from the 9th beat; mac_result = 1023.
- Reset mid-operation: rst pulsed after 4 beats -> all outputs 0 and FSM in IDLE. A following clean 8-beat operation of lane0 = 0x01 gives mac_result = 255.
